// File: rtl/visaccum_pkg.sv
// rtl/visaccum_pkg.sv - shared state encoding and address-width helper for the visibility accumulator
package visaccum_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARMED = 2'd1,
        ST_RUN   = 2'd2
    } state_e;

    // Width of a word index covering 0..n-1; never below one bit.
    function automatic int calc_abits(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/visaccum_ctrl_pass_counter.sv
// rtl/visaccum_ctrl_pass_counter.sv - word-index / pass-index counter pair with wrap and block flags
module pass_counter
    import visaccum_pkg::*;
#(
    parameter int NSUMS = 1024,
    parameter int ABITS = calc_abits(NSUMS),
    parameter int CBITS = 16
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             start_i,
    input  logic             clear_i,
    input  logic             step_i,
    input  logic [CBITS-1:0] nlat_i,
    output logic [ABITS-1:0] widx_o,
    output logic             first_o,
    output logic             last_o,
    output logic             final_o
);

    logic [ABITS-1:0] widx_q, widx_d, base_widx;
    logic [CBITS-1:0] pcnt_q, pcnt_d, base_pcnt;
    logic             wrap;

    // A start evaluates the current word as word 0 of pass 0, whatever the registers hold.
    assign base_widx = start_i ? '0 : widx_q;
    assign base_pcnt = start_i ? '0 : pcnt_q;
    assign wrap      = (base_widx == ABITS'(NSUMS - 1));
    assign first_o   = (base_pcnt == '0);
    assign last_o    = (base_pcnt == nlat_i - CBITS'(1));
    assign final_o   = wrap && last_o;
    assign widx_o    = widx_q;

    always_comb begin
        widx_d = widx_q;
        pcnt_d = pcnt_q;
        if (step_i) begin
            if (wrap) begin
                widx_d = '0;
                pcnt_d = final_o ? '0 : base_pcnt + CBITS'(1);
            end else begin
                widx_d = base_widx + ABITS'(1);
                pcnt_d = base_pcnt;
            end
        end else if (clear_i) begin
            widx_d = '0;
            pcnt_d = '0;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            widx_q <= '0;
            pcnt_q <= '0;
        end else begin
            widx_q <= widx_d;
            pcnt_q <= pcnt_d;
        end
    end

endmodule

// File: rtl/visaccum_ctrl.sv
// rtl/visaccum_ctrl.sv - frames correlator partial-visibility words into accumulation blocks
module visaccum_ctrl
    import visaccum_pkg::*;
#(
    parameter int IBITS = 7,
    parameter int NSUMS = 1024,
    parameter int CBITS = 16
) (
    input  logic             clock_i,
    input  logic             reset_ni,
    input  logic             enable_i,
    input  logic [CBITS-1:0] count_i,
    input  logic             valid_i,
    input  logic             sof_i,
    input  logic [IBITS-1:0] data_i,
    output logic             valid_o,
    output logic             first_o,
    output logic             last_o,
    output logic [IBITS-1:0] data_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             desync_o,
    output logic [15:0]      blocks_o
);

    localparam int ABITS = calc_abits(NSUMS);

    state_e           state_q, state_d;
    logic [CBITS-1:0] nlat_q, nlat_d, nlat_sampled, nlat_eff;
    logic [ABITS-1:0] widx;
    logic             start, clear, fwd, pc_first, pc_last, pc_final;
    logic             done_d, desync_d;
    logic [15:0]      blocks_d;
    logic             valid_q, first_q, last_q, busy_q, done_q, desync_q;
    logic [IBITS-1:0] data_q;
    logic [15:0]      blocks_q;

    assign nlat_sampled = (count_i == '0) ? CBITS'(1) : count_i;
    assign nlat_eff     = start ? nlat_sampled : nlat_q;

    pass_counter #(.NSUMS(NSUMS), .ABITS(ABITS), .CBITS(CBITS)) u_pass_counter (
        .clock_i  (clock_i),
        .reset_ni (reset_ni),
        .start_i  (start),
        .clear_i  (clear),
        .step_i   (fwd),
        .nlat_i   (nlat_eff),
        .widx_o   (widx),
        .first_o  (pc_first),
        .last_o   (pc_last),
        .final_o  (pc_final)
    );

    always_comb begin
        state_d  = state_q;
        nlat_d   = nlat_q;
        start    = 1'b0;
        clear    = 1'b0;
        fwd      = 1'b0;
        done_d   = 1'b0;
        desync_d = desync_q;
        blocks_d = blocks_q;
        case (state_q)
            ST_IDLE: begin
                if (enable_i) state_d = ST_ARMED;
            end
            ST_ARMED: begin
                if (!enable_i) begin
                    state_d = ST_IDLE;
                end else if (valid_i && sof_i) begin
                    start   = 1'b1;
                    fwd     = 1'b1;
                    nlat_d  = nlat_sampled;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                if (valid_i) begin
                    // Misaligned sof abandons the block; a sof word restarts at once.
                    if (sof_i != (widx == '0)) begin
                        desync_d = 1'b1;
                        clear    = 1'b1;
                        if (sof_i) begin
                            start  = 1'b1;
                            fwd    = 1'b1;
                            nlat_d = nlat_sampled;
                        end else begin
                            state_d = ST_ARMED;
                        end
                    end else begin
                        fwd = 1'b1;
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
        if (fwd && pc_final) begin
            done_d   = 1'b1;
            blocks_d = blocks_q + 16'd1;
            state_d  = enable_i ? ST_ARMED : ST_IDLE;
        end
    end

    always_ff @(posedge clock_i or negedge reset_ni) begin
        if (!reset_ni) begin
            state_q  <= ST_IDLE;
            nlat_q   <= CBITS'(1);
            valid_q  <= 1'b0;
            first_q  <= 1'b0;
            last_q   <= 1'b0;
            data_q   <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            desync_q <= 1'b0;
            blocks_q <= '0;
        end else begin
            state_q  <= state_d;
            nlat_q   <= nlat_d;
            valid_q  <= fwd;
            first_q  <= fwd && pc_first;
            last_q   <= fwd && pc_last;
            data_q   <= data_i;
            busy_q   <= (state_d != ST_IDLE);
            done_q   <= done_d;
            desync_q <= desync_d;
            blocks_q <= blocks_d;
        end
    end

    assign valid_o  = valid_q;
    assign first_o  = first_q;
    assign last_o   = last_q;
    assign data_o   = data_q;
    assign busy_o   = busy_q;
    assign done_o   = done_q;
    assign desync_o = desync_q;
    assign blocks_o = blocks_q;

endmodule
